fir_output_quantizer: RTL and testbench

//  Consumer end of the FIR output interface: takes the full-precision signed o_sig word each clock,

---
 rtl/fir_output_quantizer.sv | 179 +++++++++++++++++
 tb/tb_fir_output_quantizer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_output_quantizer.sv
// FIR output quantizer: drops the filter start-up transient, rescales/saturates each sample
// and queues it in a first-word-fall-through FIFO. Optional round-half-up via FIR_OQ_ROUND_EN.
module fir_output_quantizer #(
  parameter int DATA_WIDTH        = 16,
  parameter int COEFFICIENT_WIDTH = 16,
  parameter int FILTER_LENGTH     = 71,
  parameter int SHIFT             = 15,
  parameter int OUT_WIDTH         = 16,
  parameter int FIFO_DEPTH        = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       i_en,
  input  logic [DATA_WIDTH+COEFFICIENT_WIDTH-1:0]    i_sig,
  output logic [OUT_WIDTH-1:0]                       o_data,
  output logic                                       o_valid,
  input  logic                                       i_ready,
  output logic [15:0]                                o_sat_cnt,
  output logic [15:0]                                o_drop_cnt
);

  localparam int IN_W  = DATA_WIDTH + COEFFICIENT_WIDTH;
  localparam int SUM_W = IN_W + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int WCW   = (FILTER_LENGTH > 2) ? $clog2(FILTER_LENGTH) : 1;

  localparam logic [WCW-1:0] LAST_DISCARD = WCW'(FILTER_LENGTH - 1);

`ifdef FIR_OQ_ROUND_EN
  localparam logic [SUM_W-1:0] ROUND_VAL = (SUM_W'(1) << SHIFT) >> 1;
`else
  localparam logic [SUM_W-1:0] ROUND_VAL = '0;
`endif

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_STREAM
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   warm_q, warm_d;
  logic             capture;

  logic             s1_valid;
  logic [SUM_W-1:0] s1_sum;

  logic signed [SUM_W-1:0] shifted;
  logic signed [SUM_W-1:0] clamped;
  logic                    sat_hit;
  logic [OUT_WIDTH-1:0]    q_data;

  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 fifo_empty, fifo_full;
  logic                 do_pop, do_push, do_drop;

  logic [15:0] sat_cnt, drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  // The sample that leaves IDLE is already warm-up sample #1, so short filters skip WARMUP.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    capture = 1'b0;
    if (!i_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (FILTER_LENGTH == 1) begin
            state_d = ST_STREAM;
            capture = 1'b1;
          end else begin
            warm_d  = WCW'(1);
            state_d = (FILTER_LENGTH == 2) ? ST_STREAM : ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          warm_d = warm_q + WCW'(1);
          if (warm_q + WCW'(1) == LAST_DISCARD) begin
            state_d = ST_STREAM;
          end
        end
        ST_STREAM: begin
          capture = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else begin
      s1_valid <= capture;
      if (capture) begin
        s1_sum <= {i_sig[IN_W-1], i_sig} + ROUND_VAL;
      end
    end
  end

  always_comb begin
    shifted = $signed(s1_sum) >>> SHIFT;
    clamped = shifted;
    sat_hit = 1'b0;
    if (shifted > SAT_MAX) begin
      clamped = SAT_MAX;
      sat_hit = 1'b1;
    end else if (shifted < SAT_MIN) begin
      clamped = SAT_MIN;
      sat_hit = 1'b1;
    end
    q_data = OUT_WIDTH'(clamped);
  end

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop     = !fifo_empty && i_ready;
  assign do_push    = s1_valid && (!fifo_full || do_pop);
  assign do_drop    = s1_valid && fifo_full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= q_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (s1_valid && sat_hit && (sat_cnt != 16'hFFFF)) begin
        sat_cnt <= sat_cnt + 16'd1;
      end
      if (do_drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign o_valid    = !fifo_empty;
  assign o_data     = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign o_sat_cnt  = sat_cnt;
  assign o_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_fir_output_quantizer.sv
// Bench for fir_output_quantizer: directed scenarios plus randomized traffic compared
// every cycle against a queue-based reference model of the stream.
module tb_fir_output_quantizer;

  localparam int FL    = 71;
  localparam int SH    = 15;
  localparam int DEPTH = 16;
`ifdef FIR_OQ_ROUND_EN
  localparam longint RND = 64'sd1 <<< (SH - 1);
`else
  localparam longint RND = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, i_en, i_ready;
  logic [31:0] i_sig;
  logic [15:0] o_data, o_sat_cnt, o_drop_cnt;
  logic        o_valid;

  int num_checks = 0;
  int num_fail   = 0;

  int          run_len = 0;
  bit          pend_v = 1'b0;
  logic [15:0] pend_val = '0;
  bit          pend_sat = 1'b0;
  logic [15:0] mq[$];
  int          m_sat = 0;
  int          m_drop = 0;

  always #5 clk = ~clk;

  fir_output_quantizer dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_sig      (i_sig),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sat_cnt  (o_sat_cnt),
    .o_drop_cnt (o_drop_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void quantize(input logic [31:0] x, output logic [15:0] v, output bit sat);
    longint t;
    t   = longint'($signed(x)) + RND;
    t   = t >>> SH;
    sat = 1'b0;
    if (t > 32767) begin
      t   = 32767;
      sat = 1'b1;
    end else if (t < -32768) begin
      t   = -32768;
      sat = 1'b1;
    end
    v = t[15:0];
  endfunction

  // Sample k of an unbroken enable run is delivered once k >= FL, two edges later.
  task automatic modelStep(input logic r, input logic e, input logic [31:0] s, input logic rdy);
    if (r) begin
      run_len = 0;
      pend_v  = 1'b0;
      mq.delete();
      m_sat   = 0;
      m_drop  = 0;
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (pend_v) begin
        if (pend_sat && m_sat < 65535) m_sat++;
        if (mq.size() < DEPTH) mq.push_back(pend_val);
        else if (m_drop < 65535) m_drop++;
      end
      pend_v = 1'b0;
      if (e) begin
        run_len++;
        if (run_len >= FL) begin
          pend_v = 1'b1;
          quantize(s, pend_val, pend_sat);
        end
      end else begin
        run_len = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [31:0] s, input logic rdy);
    logic [15:0] exp_data;
    rst     = r;
    i_en    = e;
    i_sig   = s;
    i_ready = rdy;
    @(posedge clk);
    modelStep(r, e, s, rdy);
    @(negedge clk);
    exp_data = (mq.size() > 0) ? mq[0] : 16'h0000;
    checkOutput("model_valid", 32'(o_valid), 32'(mq.size() > 0));
    checkOutput("model_data", 32'(o_data), 32'(exp_data));
    checkOutput("model_sat_cnt", 32'(o_sat_cnt), 32'(m_sat));
    checkOutput("model_drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
  endtask

  task automatic warmUp(input logic rdy);
    applyStimulus(1'b1, 1'b0, 32'h0, rdy);
    applyStimulus(1'b1, 1'b0, 32'h0, rdy);
    repeat (FL - 1) applyStimulus(1'b0, 1'b1, 32'h0, rdy);
  endtask

  initial begin
    int first, delivered, tmp, run_left, ready_pct;
    logic en_cur, r;
    logic [31:0] s;

    // Reset state
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_data", 32'(o_data), 32'd0);
    checkOutput("reset_sat", 32'(o_sat_cnt), 32'd0);
    checkOutput("reset_drop", 32'(o_drop_cnt), 32'd0);

    // Warm-up latency and delivered count
    first = 0;
    delivered = 0;
    for (int c = 1; c <= 80; c++) begin
      applyStimulus(1'b0, 1'b1, 32'h0000_8000, 1'b1);
      if (o_valid && first == 0) begin
        first = c;
        checkOutput("warmup_first_data", 32'(o_data), 32'd1);
      end
      if (o_valid) delivered++;
    end
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      if (o_valid) delivered++;
    end
    checkOutput("warmup_first_valid", 32'(first), 32'd72);
    checkOutput("warmup_delivered", 32'(delivered), 32'd10);

    // Saturation at both rails
    warmUp(1'b0);
    applyStimulus(1'b0, 1'b1, 32'h4000_0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hC000_0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("sat_pos_data", 32'(o_data), 32'h7FFF);
    checkOutput("sat_pos_cnt", 32'(o_sat_cnt), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("sat_neg_data", 32'(o_data), 32'h8000);
    checkOutput("sat_neg_cnt", 32'(o_sat_cnt), 32'd1);

    // Rounding versus truncation at half an LSB
    warmUp(1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_4000, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_C000, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
`ifdef FIR_OQ_ROUND_EN
    checkOutput("round_pos_half", 32'(o_data), 32'h0001);
`else
    checkOutput("round_pos_half", 32'(o_data), 32'h0000);
`endif
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef FIR_OQ_ROUND_EN
    checkOutput("round_neg_half", 32'(o_data), 32'h0000);
`else
    checkOutput("round_neg_half", 32'(o_data), 32'hFFFF);
`endif

    // Backpressure: overflow drops, then in-order drain
    warmUp(1'b0);
    for (int k = 1; k <= 20; k++) applyStimulus(1'b0, 1'b1, 32'(k) << 15, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bp_drop_cnt", 32'(o_drop_cnt), 32'd4);
    for (int k = 1; k <= 16; k++) begin
      checkOutput("bp_order", 32'(o_data), 32'(k));
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    end
    checkOutput("bp_drained", 32'(o_valid), 32'd0);

    // Reset with entries queued, then warm-up restarts
    warmUp(1'b0);
    for (int k = 1; k <= 5; k++) applyStimulus(1'b0, 1'b1, 32'(k) << 15, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("midrst_queued", 32'(o_valid), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b1);
    checkOutput("midrst_valid", 32'(o_valid), 32'd0);
    first = 0;
    for (int c = 1; c <= 75; c++) begin
      applyStimulus(1'b0, 1'b1, 32'h0001_8000, 1'b1);
      if (o_valid && first == 0) first = c;
    end
    checkOutput("midrst_first_valid", 32'(first), 32'd72);

    // Randomized traffic against the model
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    en_cur = 1'b0;
    run_left = 0;
    ready_pct = 80;
    for (int n = 0; n < 2500; n++) begin
      if (run_left == 0) begin
        en_cur    = ~en_cur;
        run_left  = en_cur ? int'($urandom_range(30, 200)) : int'($urandom_range(1, 4));
        ready_pct = ($urandom_range(0, 2) == 0) ? 15 : 85;
      end
      run_left--;
      case ($urandom_range(0, 3))
        0: tmp = int'($urandom());
        1: tmp = int'($urandom_range(0, 4194303)) - 2097152;
        2: tmp = (($urandom_range(0, 1) == 1) ? 32767 : -32768) * 32768
                 + int'($urandom_range(0, 65535)) - 32768;
        default: tmp = (int'($urandom_range(0, 200)) - 100) * 32768 + 16384;
      endcase
      s = 32'(tmp);
      r = ($urandom_range(0, 599) == 0);
      applyStimulus(r, en_cur, s, ($urandom_range(0, 99) < ready_pct));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
